// File: rtl/text_pkg.sv
// Shared types and constants for the binary-to-decimal text streamer.
// Holds the FSM state enum, ASCII constants and the double-dabble digit adjust.
package text_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_DASH  = 8'h2D;

   // Double-dabble pre-shift correction: a digit >= 5 would exceed 9 after doubling.
   function automatic logic [3:0] add3_digit(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, MSB first.
// A start pulse loads the value; done pulses one cycle after the final shift.
module bin_to_bcd_seq
   import text_pkg::*;
#(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   logic [BIN_W-1:0]    sh_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                busy_q;
   logic [4*DIGITS-1:0] adj;

   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         adj[4*i +: 4] = add3_digit(bcd[4*i +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         sh_q     <= '0;
         cnt_q    <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            sh_q     <= bin;
            bcd      <= '0;
            overflow <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
         end else if (busy_q) begin
            // The bit leaving the top digit is lost precision, so it is kept as a sticky flag.
            bcd      <= {adj[4*DIGITS-2:0], sh_q[BIN_W-1]};
            overflow <= overflow | adj[4*DIGITS-1];
            sh_q     <= sh_q << 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               busy_q <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bin_to_text_stream.sv
// Converts an unsigned binary value into a fixed-width stream of ASCII decimal
// characters, most significant first, with optional leading-zero blanking.
module bin_to_text_stream
   import text_pkg::*;
#(
   parameter int         BIN_W    = 10,
   parameter int         DIGITS   = 3,
   parameter bit         BLANK_LZ = 1'b1,
   parameter logic [7:0] PAD_CHAR = 8'h20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIN_W-1:0] in_bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             out_last,
   output logic             out_overflow
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   // Handshakes: a transfer happens on a rising edge where valid && ready; a
   // producer holds valid and its payload unchanged until that transfer.
   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [7:0]          char_q, char_d;
   logic                start;
   logic                conv_done;
   logic                conv_ovf;
   logic [4*DIGITS-1:0] bcd;
   logic [7:0]          chars [DIGITS];
   logic                seen_nz;
   logic [3:0]          digit;

   assign in_ready = (state_q == IDLE);
   assign start    = in_valid && in_ready;

   bin_to_bcd_seq #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin      (in_bin),
      .done     (conv_done),
      .bcd      (bcd),
      .overflow (conv_ovf)
   );

   // chars[0] is the most significant digit; bcd stays frozen throughout EMIT.
   always_comb begin
      seen_nz = 1'b0;
      digit   = '0;
      for (int i = 0; i < DIGITS; i++) begin
         digit = bcd[4*(DIGITS-1-i) +: 4];
         if (digit != 4'd0) seen_nz = 1'b1;
         if (conv_ovf)
            chars[i] = ASCII_DASH;
         else if (BLANK_LZ && !seen_nz && (i != DIGITS - 1))
            chars[i] = PAD_CHAR;
         else
            chars[i] = ASCII_ZERO + {4'h0, digit};
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      char_d  = char_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CONVERT;
               idx_d   = '0;
               char_d  = 8'h00;
            end
         end
         CONVERT: begin
            if (conv_done) begin
               state_d = EMIT;
               idx_d   = '0;
               char_d  = chars[0];
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  char_d  = 8'h00;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  char_d = chars[idx_d];
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            char_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         char_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         char_q  <= char_d;
      end
   end

   assign out_valid    = (state_q == EMIT);
   assign out_char     = char_q;
   assign out_last     = out_valid && (idx_q == LAST_IDX);
   assign out_overflow = out_valid && conv_ovf;

endmodule

// File: tb/tb_bin_to_text_stream.sv
// Self-checking bench for bin_to_text_stream: vector table, scoreboard queue,
// and directed sequences for latency, backpressure, reset abort and DIGITS=4.
module tb_bin_to_text_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, out_overflow;
  logic [9:0] in_bin;
  logic [7:0] out_char;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_overflow;
  logic [9:0] b_in_bin;
  logic [7:0] b_out_char;

  int errors = 0;
  int checks = 0;
  int b_accepts = 0;

  // {last, overflow, char}
  logic [9:0] exp_q[$];

  typedef struct {
    logic [9:0]  bin;
    logic [23:0] chars;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  bin_to_text_stream #(.BIN_W(10), .DIGITS(3), .BLANK_LZ(1'b1), .PAD_CHAR(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_last(out_last), .out_overflow(out_overflow)
  );

  bin_to_text_stream #(.BIN_W(10), .DIGITS(4), .BLANK_LZ(1'b0), .PAD_CHAR(8'h20)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_char(b_out_char),
    .out_last(b_out_last), .out_overflow(b_out_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [23:0] model3(input int v);
    logic [23:0] r;
    int d;
    int p;
    bit seen;
    if (v > 999) return 24'h2D2D2D;
    r = '0;
    p = 100;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = (v / p) % 10;
      p = p / 10;
      if (d != 0) seen = 1'b1;
      r = {r[15:0], (!seen && i < 2) ? 8'h20 : 8'(8'h30 + d)};
    end
    return r;
  endfunction

  task automatic push_value(input logic [23:0] chars, input logic ovf);
    for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), ovf, chars[23-8*i -: 8]});
  endtask

  task automatic send(input logic [9:0] v, input logic [23:0] chars, input logic ovf, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_bin   = v;
    if (push) push_value(chars, ovf);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_bin = 10'($urandom_range(0, 1023));
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1 if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    check("drain_left", exp_q.size(), 0);
  endtask

  // Output monitor: flag invariants, hold stability and scoreboard pops.
  logic       hold_v = 1'b0;
  logic [9:0] hold_s;
  logic [9:0] got;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (!out_valid) check("idle_flags", {out_last, out_overflow}, 0);
      if (hold_v) check("hold_stable", {out_valid, out_last, out_overflow, out_char}, {1'b1, hold_s});
      hold_v = out_valid && !out_ready;
      hold_s = {out_last, out_overflow, out_char};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_char: got %0h expected none", out_char);
        end else begin
          got = exp_q.pop_front();
          check("char", {out_last, out_overflow, out_char}, got);
        end
      end
    end
  end

  always @(posedge clk) if (rst_n && b_in_valid && b_in_ready) b_accepts++;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: run did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int n;
    int nb;
    logic [7:0] b_chars[4];
    logic [31:0] v;

    in_valid = 1'b0; in_bin = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_bin = '0; b_out_ready = 1'b1;

    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 8'h00);
    check("rst_out_last", out_last, 0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    vecs[0]  = '{10'd0,    24'h202030, 1'b0};
    vecs[1]  = '{10'd999,  24'h393939, 1'b0};
    vecs[2]  = '{10'd1000, 24'h2D2D2D, 1'b1};
    vecs[3]  = '{10'd1023, 24'h2D2D2D, 1'b1};
    vecs[4]  = '{10'd5,    24'h202035, 1'b0};
    vecs[5]  = '{10'd42,   24'h203432, 1'b0};
    vecs[6]  = '{10'd100,  24'h313030, 1'b0};
    vecs[7]  = '{10'd305,  24'h333035, 1'b0};
    vecs[8]  = '{10'd90,   24'h203930, 1'b0};
    vecs[9]  = '{10'd10,   24'h203130, 1'b0};
    vecs[10] = '{10'd512,  24'h353132, 1'b0};
    for (int i = 0; i < 11; i++) send(vecs[i].bin, vecs[i].chars, vecs[i].ovf, 1'b1);
    drain(1'b0);

    // First out_valid exactly BIN_W+1 edges after acceptance
    send(10'd999, 24'h393939, 1'b0, 1'b1);
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1 if (out_valid && first < 0) first = k;
    end
    check("latency_999", first, 11);
    drain(1'b0);

    // Backpressure holds the first (blanked) character
    out_ready = 1'b0;
    send(10'd7, 24'h202037, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (5) begin
      @(posedge clk);
      #1 check("bp_char", {out_valid, out_char}, {1'b1, 8'h20});
    end
    out_ready = 1'b1;
    drain(1'b0);

    // Reset during CONVERT aborts the value
    send(10'd300, 24'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    rst_n = 1'b1;
    repeat (16) @(posedge clk);
    #1 check("abort_silent", out_valid, 0);
    send(10'd42, 24'h203432, 1'b0, 1'b1);
    drain(1'b0);

    // Random values with random backpressure
    for (int i = 0; i < 12; i++) begin
      v = $urandom_range(0, 1023);
      send(v[9:0], model3(int'(v)), (v > 999), 1'b1);
    end
    drain(1'b1);

    // DIGITS=4, no blanking, in_valid held through EMIT
    b_in_bin = 10'd42;
    b_in_valid = 1'b1;
    nb = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (b_out_valid) begin
        if (nb < 4) b_chars[nb] = b_out_char;
        check("b_last", b_out_last, (nb == 3));
        check("b_ovf", b_out_overflow, 0);
        nb++;
        if (b_out_last) break;
      end
    end
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    check("b_count", nb, 4);
    check("b_chars", {b_chars[0], b_chars[1], b_chars[2], b_chars[3]}, 32'h30303432);
    repeat (20) @(posedge clk);
    #1;
    check("b_accepts", b_accepts, 1);
    check("b_idle", {b_out_valid, b_in_ready}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
